fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-side drain engine for the single-clock FIFO. It issues FIFO read strobes, tracks reads in flight through the FIFO's fixed read latency, and captures returned words in a small skid buffer. Words are presented as a valid/ready stream. Downstream back-pressure never loses a word, and the stream sustains one word per clock when the consumer is always ready.

## Interface
- DW, 18: data width; must match the FIFO data width.
- RD_LAT, 1: cycles from FIFO read strobe to returned-data valid; legal range 1–3.
- BUF_D, RD_LAT+1 (derived, not overridable): skid-buffer entries.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-low.
- fifo_empty  in  1  FIFO empty flag; must reflect every read strobe issued up to the previous cycle.
- fifo_dout_valid  in  1  FIFO returned-data strobe, RD_LAT cycles after the corresponding read strobe.
- fifo_dout  in  DW  FIFO returned data, qualified by fifo_dout_valid.
- fifo_ren  out  1  FIFO read strobe; combinational.
- m_valid  out  1  stream word valid; registered.
- m_ready  in  1  stream consumer ready.
- m_data  out  DW  stream word; registered, stable while m_valid && !m_ready.
- level  out  $clog2(BUF_D+1)  words held in the skid buffer.
- err_unexp  out  1  sticky: returned data arrived with no read in flight.

## Operation
- Skid buffer:
  - Circular, BUF_D entries, with write pointer, read pointer and count.
  - Head entry drives m_data.
  - m_valid = (count != 0).
- In-flight counter `infl`, range 0..RD_LAT:
  - +1 on fifo_ren.
  - −1 on fifo_dout_valid.
  - Both in the same cycle: no change.
- pop = m_valid && m_ready.
- push = fifo_dout_valid:
  - Writes fifo_dout at the write pointer.
  - Pointers wrap from BUF_D−1 to 0.
- Credit rule: fifo_ren = !fifo_empty && (count + infl − pop) < BUF_D.
  - The m_ready → fifo_ren path is combinational by design.
  - This guarantees the buffer never overflows.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - Permitted when the buffer is full (count = BUF_D).
- fifo_dout_valid with infl = 0:
  - Set err_unexp.
  - Drop the word.
  - Leave count and pointers unchanged.
  - err_unexp stays set until reset.
- Ordering: words leave in exactly the order the FIFO returns them; no reordering, no duplication.

## Timing
- Reset, while rst = 0 at a clock edge, all clear the next cycle:
  - fifo_ren = 0, m_valid = 0, m_data = 0, level = 0, err_unexp = 0.
  - infl = 0; pointers = 0.
  - fifo_ren is forced 0 during reset regardless of fifo_empty.
- Reset mid-operation:
  - Buffered and in-flight words are discarded.
  - FIFO data returning after reset release, from reads issued before reset, sets err_unexp. The system resets the FIFO together with this block.
- First-word latency:
  - fifo_empty falls in cycle 0; fifo_ren asserts in cycle 0.
  - fifo_dout_valid arrives in cycle RD_LAT.
  - m_valid rises in cycle RD_LAT+1.
- Throughput:
  - With m_ready held 1 and the FIFO non-empty, fifo_ren is 1 every cycle.
  - m_valid stays 1 every cycle after the first-word latency.
- Back-pressure:
  - m_ready low stops fifo_ren once count + infl reaches BUF_D.
  - All in-flight words still land in the buffer.
- Release:
  - m_ready rising re-enables fifo_ren in the same cycle via the pop term.
  - No bubble once the buffer is full.
- FIFO running empty:
  - fifo_ren drops while fifo_empty = 1.
  - Buffered words still drain.
  - m_valid falls the cycle after the last pop.
- m_data/m_valid handshake:
  - Change only after a cycle with pop, or when the buffer goes from empty to non-empty.
  - No change while m_valid && !m_ready.

## Test plan
- Reset, RD_LAT=1, FIFO model preloaded with 0x00001..0x00008, m_ready=1 → words 1..8 out in order on 8 consecutive m_valid cycles. First m_valid is 2 cycles after rst deasserts with fifo_empty low. fifo_ren high for exactly 8 cycles.
- RD_LAT=2, m_ready=0, 20 words queued → exactly 3 fifo_ren pulses. level settles at 3. m_data=word 0 holds stable. Raising m_ready then yields words 0..19 with no gaps.
- RD_LAT=3, m_ready toggled by a random pattern (50%), 200 words → output sequence identical to input. level never exceeds 4. No err_unexp.
- FIFO holds 1 word, m_ready=1 → single fifo_ren pulse; one m_valid cycle carrying that word; fifo_ren stays 0 while fifo_empty=1.
- Inject fifo_dout_valid=1 with no prior fifo_ren → err_unexp=1 next cycle and stays 1. level stays 0 and m_valid stays 0 until rst=0 clears it.
- Assert rst=0 for one cycle with level=2 and infl=1 → next cycle level=0, m_valid=0, fifo_ren=0. The stray return then sets err_unexp.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side drain engine for the single-clock FIFO.
// Read strobes are issued against a credit budget (buffered words plus
// reads still travelling through the FIFO read latency). Returned words
// land in a small circular skid buffer that is presented downstream as a
// valid/ready stream. A full buffer can still accept a returning word in
// the same cycle that it pops one, so the stream runs at one word per
// clock while the consumer stays ready.
module fifo_rd_stream #(
    parameter  int DW     = 18,
    parameter  int RD_LAT = 1,
    localparam int BUF_D  = RD_LAT + 1,
    localparam int CW     = $clog2(BUF_D + 1),
    localparam int PW     = $clog2(BUF_D)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_empty,
    input  logic          fifo_dout_valid,
    input  logic [DW-1:0] fifo_dout,
    output logic          fifo_ren,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [CW-1:0] level,
    output logic          err_unexp
);

    // Skid buffer storage and bookkeeping
    logic [DW-1:0] r_buf [BUF_D];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_infl;
    logic          r_valid;
    logic          r_err;

    // Per-cycle events and next-state values
    logic          w_pop;
    logic          w_push;
    logic          w_unexp;
    logic [CW:0]   w_credit;
    logic [CW-1:0] w_count_nxt;
    logic [CW-1:0] w_infl_nxt;

    // Circular pointer advance; BUF_D need not be a power of two
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_D - 1)) ? '0 : p + PW'(1);
    endfunction

    // A returning word is only accepted when a read is actually in flight;
    // anything else is a stray word that gets flagged and dropped.
    assign w_pop    = r_valid && m_ready;
    assign w_push   = fifo_dout_valid && (r_infl != '0);
    assign w_unexp  = fifo_dout_valid && (r_infl == '0);

    // Buffered + in-flight words, less the word leaving this cycle. The pop
    // term makes m_ready feed fifo_ren combinationally so a full buffer
    // re-opens without a bubble the moment the consumer takes a word.
    assign w_credit = {1'b0, r_count} + {1'b0, r_infl} - {{CW{1'b0}}, w_pop};
    assign fifo_ren = rst && !fifo_empty && (w_credit < (CW + 1)'(BUF_D));

    assign m_valid   = r_valid;
    assign m_data    = r_buf[r_rptr];
    assign level     = r_count;
    assign err_unexp = r_err;

    // Next occupancy and next in-flight count; simultaneous inc/dec cancel
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
        w_infl_nxt = r_infl;
        case ({fifo_ren, w_push})
            2'b10:   w_infl_nxt = r_infl + CW'(1);
            2'b01:   w_infl_nxt = r_infl - CW'(1);
            default: w_infl_nxt = r_infl;
        endcase
    end

    // Skid-buffer storage: cleared on reset so m_data reads zero afterwards
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BUF_D; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_push) begin
            r_buf[r_wptr] <= fifo_dout;
        end
    end

    // Pointers, occupancy, in-flight count and registered valid
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_infl  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            r_count <= w_count_nxt;
            r_infl  <= w_infl_nxt;
            r_valid <= (w_count_nxt != '0);
        end
    end

    // Sticky flag for data returned with no read outstanding
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_unexp) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: three instances at RD_LAT = 1, 2, 3, each
// fed by a small behavioural FIFO with the matching fixed read latency.
module tb_fifo_rd_stream;

    localparam int DW   = 18;
    localparam int NI   = 3;
    localparam int MEMD = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rstN;
    logic [NI-1:0] mReady;
    logic [NI-1:0] injValid;
    logic [DW-1:0] injData;
    logic [NI-1:0] fifoEmpty;
    logic [NI-1:0] fifoRen;
    logic [NI-1:0] mValid;
    logic [NI-1:0] errUnexp;
    logic [NI-1:0] doutValid;
    logic [DW-1:0] dout  [NI];
    logic [DW-1:0] mData [NI];
    logic [2:0]    lvl   [NI];

    logic [DW-1:0] mem [NI][MEMD];
    int            wrPtr [NI];

    int checks = 0;
    int errors = 0;

    // Instance g has RD_LAT = g+1; its FIFO model returns data LAT cycles
    // after each read strobe, with an optional injected stray word.
    for (genvar g = 0; g < NI; g++) begin : gInst
        localparam int LAT = g + 1;
        localparam int LW  = $clog2(LAT + 2);
        logic [LW-1:0]  lv;
        int             rd = 0;
        logic [LAT-1:0] pv = '0;
        logic [DW-1:0]  pd [LAT];

        assign fifoEmpty[g] = (wrPtr[g] == rd);
        assign doutValid[g] = pv[LAT-1] | injValid[g];
        assign dout[g]      = injValid[g] ? injData : pd[LAT-1];
        assign lvl[g]       = 3'(lv);

        always @(posedge clk) begin
            pv[0] <= fifoRen[g];
            pd[0] <= mem[g][rd % MEMD];
            for (int k = 1; k < LAT; k++) begin
                pv[k] <= pv[k-1];
                pd[k] <= pd[k-1];
            end
            if (fifoRen[g]) rd <= rd + 1;
        end

        fifo_rd_stream #(.DW(DW), .RD_LAT(LAT)) dut (
            .clk            (clk),
            .rst            (rstN[g]),
            .fifo_empty     (fifoEmpty[g]),
            .fifo_dout_valid(doutValid[g]),
            .fifo_dout      (dout[g]),
            .fifo_ren       (fifoRen[g]),
            .m_valid        (mValid[g]),
            .m_ready        (mReady[g]),
            .m_data         (mData[g]),
            .level          (lv),
            .err_unexp      (errUnexp[g])
        );
    end

    task automatic loadWord(input int g, input logic [DW-1:0] w);
        mem[g][wrPtr[g] % MEMD] = w;
        wrPtr[g] = wrPtr[g] + 1;
    endtask

    // All instances held in reset; outputs cleared, fifo_ren gated by reset
    task automatic test_reset;
        for (int g = 0; g < NI; g++) begin
            checks++; if (fifoRen[g] !== 1'b0) begin errors++; $display("[TB] FAIL reset_ren%0d got=%b exp=0", g, fifoRen[g]); end
            checks++; if (mValid[g] !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid%0d got=%b exp=0", g, mValid[g]); end
            checks++; if (mData[g] !== '0) begin errors++; $display("[TB] FAIL reset_data%0d got=%0h exp=0", g, mData[g]); end
            checks++; if (lvl[g] !== 3'd0) begin errors++; $display("[TB] FAIL reset_level%0d got=%0d exp=0", g, lvl[g]); end
            checks++; if (errUnexp[g] !== 1'b0) begin errors++; $display("[TB] FAIL reset_err%0d got=%b exp=0", g, errUnexp[g]); end
        end
        // Preload instance 0 while still in reset: strobe must stay low
        @(negedge clk);
        for (int k = 1; k <= 8; k++) loadWord(0, 18'(k));
        #1;
        checks++; if (fifoRen[0] !== 1'b0) begin errors++; $display("[TB] FAIL reset_ren_nonempty got=%b exp=0", fifoRen[0]); end
    endtask

    // RD_LAT=1, words 1..8, consumer always ready
    task automatic test_stream;
        logic expRen, expV;
        @(negedge clk);
        mReady[0] = 1'b1;
        rstN[0]   = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            expRen = (k < 8);
            expV   = (k >= 2) && (k < 10);
            checks++; if (fifoRen[0] !== expRen) begin errors++; $display("[TB] FAIL stream_ren c%0d got=%b exp=%b", k, fifoRen[0], expRen); end
            checks++; if (mValid[0] !== expV) begin errors++; $display("[TB] FAIL stream_valid c%0d got=%b exp=%b", k, mValid[0], expV); end
            if (expV) begin
                checks++; if (mData[0] !== 18'(k - 1)) begin errors++; $display("[TB] FAIL stream_data c%0d got=%0h exp=%0h", k, mData[0], k - 1); end
            end
            @(negedge clk);
        end
        #1;
        checks++; if (lvl[0] !== 3'd0) begin errors++; $display("[TB] FAIL stream_level_end got=%0d exp=0", lvl[0]); end
    endtask

    // RD_LAT=2, consumer stalled with 20 words queued, then released
    task automatic test_backpressure;
        int renCount = 0;
        @(negedge clk);
        mReady[1] = 1'b0;
        for (int k = 0; k < 20; k++) loadWord(1, 18'h200 + 18'(k));
        for (int k = 0; k < 10; k++) begin
            #1;
            if (fifoRen[1]) renCount++;
            if (k >= 3) begin
                checks++; if (mValid[1] !== 1'b1 || mData[1] !== 18'h200) begin errors++; $display("[TB] FAIL bp_hold c%0d got=%b/%0h exp=1/200", k, mValid[1], mData[1]); end
            end
            @(negedge clk);
        end
        #1;
        checks++; if (renCount != 3) begin errors++; $display("[TB] FAIL bp_ren_pulses got=%0d exp=3", renCount); end
        checks++; if (lvl[1] !== 3'd3) begin errors++; $display("[TB] FAIL bp_level got=%0d exp=3", lvl[1]); end
        @(negedge clk);
        mReady[1] = 1'b1;
        #1;
        checks++; if (fifoRen[1] !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ren got=%b exp=1", fifoRen[1]); end
        for (int k = 0; k < 20; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            checks++; if (mValid[1] !== 1'b1 || mData[1] !== 18'h200 + 18'(k)) begin errors++; $display("[TB] FAIL bp_drain w%0d got=%b/%0h exp=1/%0h", k, mValid[1], mData[1], 18'h200 + 18'(k)); end
        end
        @(negedge clk); #1;
        checks++; if (mValid[1] !== 1'b0 || lvl[1] !== 3'd0) begin errors++; $display("[TB] FAIL bp_empty got=%b/%0d exp=0/0", mValid[1], lvl[1]); end
    endtask

    // RD_LAT=3, 200 words with random ready; order, stability, level bound
    task automatic test_random_ready;
        int            got = 0;
        int            maxLvl = 0;
        logic          stalledPrev = 1'b0;
        logic [DW-1:0] prevData = '0;
        @(negedge clk);
        for (int k = 0; k < 200; k++) loadWord(2, 18'(k * 37 + 5));
        for (int cyc = 0; cyc < 3000 && got < 200; cyc++) begin
            mReady[2] = 1'($urandom_range(0, 1));
            #1;
            if (int'(lvl[2]) > maxLvl) maxLvl = int'(lvl[2]);
            if (stalledPrev) begin
                checks++; if (mValid[2] !== 1'b1 || mData[2] !== prevData) begin errors++; $display("[TB] FAIL rnd_stable c%0d got=%b/%0h exp=1/%0h", cyc, mValid[2], mData[2], prevData); end
            end
            if (mValid[2] && mReady[2]) begin
                checks++; if (mData[2] !== 18'(got * 37 + 5)) begin errors++; $display("[TB] FAIL rnd_order w%0d got=%0h exp=%0h", got, mData[2], 18'(got * 37 + 5)); end
                got++;
            end
            stalledPrev = mValid[2] && !mReady[2];
            prevData    = mData[2];
            @(negedge clk);
        end
        mReady[2] = 1'b0;
        #1;
        checks++; if (got != 200) begin errors++; $display("[TB] FAIL rnd_count got=%0d exp=200", got); end
        checks++; if (maxLvl > 4) begin errors++; $display("[TB] FAIL rnd_max_level got=%0d exp<=4", maxLvl); end
        checks++; if (errUnexp[2] !== 1'b0) begin errors++; $display("[TB] FAIL rnd_err got=%b exp=0", errUnexp[2]); end
        checks++; if (mValid[2] !== 1'b0) begin errors++; $display("[TB] FAIL rnd_valid_end got=%b exp=0", mValid[2]); end
    endtask

    // RD_LAT=1, a single word through an otherwise empty FIFO
    task automatic test_single_word;
        logic expRen, expV;
        @(negedge clk);
        loadWord(0, 18'h2ABCD);
        for (int k = 0; k < 8; k++) begin
            #1;
            expRen = (k == 0);
            expV   = (k == 2);
            checks++; if (fifoRen[0] !== expRen) begin errors++; $display("[TB] FAIL single_ren c%0d got=%b exp=%b", k, fifoRen[0], expRen); end
            checks++; if (mValid[0] !== expV) begin errors++; $display("[TB] FAIL single_valid c%0d got=%b exp=%b", k, mValid[0], expV); end
            if (expV) begin
                checks++; if (mData[0] !== 18'h2ABCD) begin errors++; $display("[TB] FAIL single_data got=%0h exp=2abcd", mData[0]); end
            end
            @(negedge clk);
        end
    endtask

    // Stray returned word with nothing in flight: sticky error, no buffering
    task automatic test_unexpected;
        @(negedge clk);
        injData     = 18'h15555;
        injValid[0] = 1'b1;
        #1;
        checks++; if (errUnexp[0] !== 1'b0) begin errors++; $display("[TB] FAIL unexp_before got=%b exp=0", errUnexp[0]); end
        @(negedge clk);
        injValid[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (errUnexp[0] !== 1'b1) begin errors++; $display("[TB] FAIL unexp_err c%0d got=%b exp=1", k, errUnexp[0]); end
            checks++; if (lvl[0] !== 3'd0 || mValid[0] !== 1'b0) begin errors++; $display("[TB] FAIL unexp_buf c%0d got=%0d/%b exp=0/0", k, lvl[0], mValid[0]); end
            @(negedge clk);
        end
        rstN[0] = 1'b0;
        @(negedge clk);
        rstN[0] = 1'b1;
        #1;
        checks++; if (errUnexp[0] !== 1'b0) begin errors++; $display("[TB] FAIL unexp_cleared got=%b exp=0", errUnexp[0]); end
    endtask

    // RD_LAT=2, reset with two words buffered and one read in flight
    task automatic test_reset_midflight;
        @(negedge clk);
        mReady[1] = 1'b0;
        loadWord(1, 18'h00A1);
        loadWord(1, 18'h00B2);
        #1;
        checks++; if (fifoRen[1] !== 1'b1) begin errors++; $display("[TB] FAIL mid_ren0 got=%b exp=1", fifoRen[1]); end
        @(negedge clk); #1;
        checks++; if (fifoRen[1] !== 1'b1) begin errors++; $display("[TB] FAIL mid_ren1 got=%b exp=1", fifoRen[1]); end
        @(negedge clk); #1;
        checks++; if (fifoRen[1] !== 1'b0) begin errors++; $display("[TB] FAIL mid_ren2 got=%b exp=0", fifoRen[1]); end
        @(negedge clk);
        loadWord(1, 18'h00C3);
        #1;
        checks++; if (fifoRen[1] !== 1'b1 || lvl[1] !== 3'd1) begin errors++; $display("[TB] FAIL mid_ren3 got=%b/%0d exp=1/1", fifoRen[1], lvl[1]); end
        @(negedge clk); #1;
        checks++; if (lvl[1] !== 3'd2 || mData[1] !== 18'h00A1) begin errors++; $display("[TB] FAIL mid_pre_reset got=%0d/%0h exp=2/a1", lvl[1], mData[1]); end
        rstN[1] = 1'b0;
        #1;
        checks++; if (fifoRen[1] !== 1'b0) begin errors++; $display("[TB] FAIL mid_ren_in_reset got=%b exp=0", fifoRen[1]); end
        @(negedge clk);
        rstN[1] = 1'b1;
        #1;
        checks++; if (lvl[1] !== 3'd0 || mValid[1] !== 1'b0) begin errors++; $display("[TB] FAIL mid_after_reset got=%0d/%b exp=0/0", lvl[1], mValid[1]); end
        checks++; if (fifoRen[1] !== 1'b0 || mData[1] !== '0) begin errors++; $display("[TB] FAIL mid_after_reset_ren_data got=%b/%0h exp=0/0", fifoRen[1], mData[1]); end
        checks++; if (errUnexp[1] !== 1'b0) begin errors++; $display("[TB] FAIL mid_err_early got=%b exp=0", errUnexp[1]); end
        @(negedge clk); #1;
        checks++; if (errUnexp[1] !== 1'b1) begin errors++; $display("[TB] FAIL mid_stray_err got=%b exp=1", errUnexp[1]); end
        checks++; if (lvl[1] !== 3'd0 || mValid[1] !== 1'b0) begin errors++; $display("[TB] FAIL mid_stray_dropped got=%0d/%b exp=0/0", lvl[1], mValid[1]); end
    endtask

    // Watchdog so the run can never hang
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired before the summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rstN     = '0;
        mReady   = '0;
        injValid = '0;
        injData  = '0;
        for (int g = 0; g < NI; g++) wrPtr[g] = 0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        @(negedge clk);
        rstN[2:1] = 2'b11;
        test_stream();
        test_backpressure();
        test_random_ready();
        test_single_word();
        test_unexpected();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
